// File: rtl/board_pkg.sv
// Shared types and line geometry for the tic-tac-toe board store.
// A "line" is a row, column, main diagonal or anti-diagonal of a SIDE x SIDE board.
package board_pkg;

  typedef enum logic [1:0] {READY, SNAP, CLEAR} state_t;

  localparam logic [2:0] GO_NONE = 3'd0;
  localparam logic [2:0] GO_ROW  = 3'd1;
  localparam logic [2:0] GO_COL  = 3'd2;
  localparam logic [2:0] GO_DIAG = 3'd3;
  localparam logic [2:0] GO_ANTI = 3'd4;
  localparam logic [2:0] GO_DRAW = 3'd5;

  // Scan order: rows, columns, main diagonal, anti-diagonal.
  function automatic int line_cell(int side, int line, int pos);
    if (line < side)           return line * side + pos;
    else if (line < 2 * side)  return pos * side + (line - side);
    else if (line == 2 * side) return pos * side + pos;
    else                       return pos * side + (side - 1 - pos);
  endfunction

  function automatic logic [2:0] line_kind(int side, int line);
    if (line < side)           return GO_ROW;
    else if (line < 2 * side)  return GO_COL;
    else if (line == 2 * side) return GO_DIAG;
    else                       return GO_ANTI;
  endfunction

  function automatic int line_index(int side, int line);
    if (line < side)          return line;
    else if (line < 2 * side) return line - side;
    else                      return 0;
  endfunction

endpackage

// File: rtl/win_scanner.sv
// Sequential win/draw scanner: walks every line one cell per cycle and latches
// the pass result into go_* after the last cell of the last line.
module win_scanner
  import board_pkg::*;
#(
  parameter int SIDE   = 4,
  parameter int CELL_W = 2,
  parameter int AW     = $clog2(SIDE * SIDE),
  parameter int IW     = $clog2(SIDE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart_i,
  input  logic              clear_go_i,
  input  logic [CELL_W-1:0] cell_i,
  output logic [AW-1:0]     cell_addr_o,
  output logic              go_valid_o,
  output logic [2:0]        go_kind_o,
  output logic [IW-1:0]     go_index_o,
  output logic [CELL_W-1:0] go_winner_o
);

  localparam int NLINES = 2 * SIDE + 2;
  localparam int LW     = $clog2(NLINES);

  logic [LW-1:0]     line_q, line_d;
  logic [IW-1:0]     pos_q, pos_d;
  logic [CELL_W-1:0] first_q, first_d;
  logic              eq_q, eq_d;
  logic              empty_q, empty_d;
  logic              found_q, found_d;
  logic [2:0]        fkind_q, fkind_d;
  logic [IW-1:0]     fidx_q, fidx_d;
  logic [CELL_W-1:0] fmark_q, fmark_d;
  logic              go_valid_q, go_valid_d;
  logic [2:0]        go_kind_q, go_kind_d;
  logic [IW-1:0]     go_index_q, go_index_d;
  logic [CELL_W-1:0] go_winner_q, go_winner_d;

  logic [CELL_W-1:0] first_cur, mark_cur;
  logic              eq_cur, empty_cur, last_pos, last_line, win_now, found_cur;
  logic [2:0]        kind_cur;
  logic [IW-1:0]     idx_cur;

  assign cell_addr_o = AW'(line_cell(SIDE, int'(line_q), int'(pos_q)));

  assign first_cur = (pos_q == '0) ? cell_i : first_q;
  assign eq_cur    = (pos_q == '0) ? (cell_i != '0) : (eq_q && (cell_i == first_q));
  assign empty_cur = empty_q || (cell_i == '0);
  assign last_pos  = (pos_q == IW'(SIDE - 1));
  assign last_line = (line_q == LW'(NLINES - 1));
  // Only the first winning line of a pass is recorded.
  assign win_now   = last_pos && eq_cur && !found_q;
  assign found_cur = found_q || win_now;
  assign kind_cur  = win_now ? line_kind(SIDE, int'(line_q)) : fkind_q;
  assign idx_cur   = win_now ? IW'(line_index(SIDE, int'(line_q))) : fidx_q;
  assign mark_cur  = win_now ? first_cur : fmark_q;

  always_comb begin
    line_d      = line_q;
    pos_d       = pos_q + 1'b1;
    first_d     = first_cur;
    eq_d        = eq_cur;
    empty_d     = empty_cur;
    found_d     = found_cur;
    fkind_d     = kind_cur;
    fidx_d      = idx_cur;
    fmark_d     = mark_cur;
    go_valid_d  = go_valid_q;
    go_kind_d   = go_kind_q;
    go_index_d  = go_index_q;
    go_winner_d = go_winner_q;

    if (last_pos) begin
      pos_d = '0;
      if (last_line) begin
        line_d      = '0;
        go_valid_d  = found_cur || !empty_cur;
        go_kind_d   = found_cur ? kind_cur : (empty_cur ? GO_NONE : GO_DRAW);
        go_index_d  = found_cur ? idx_cur : '0;
        go_winner_d = found_cur ? mark_cur : '0;
        empty_d     = 1'b0;
        found_d     = 1'b0;
        fkind_d     = GO_NONE;
        fidx_d      = '0;
        fmark_d     = '0;
      end else begin
        line_d = line_q + 1'b1;
      end
    end

    if (restart_i) begin
      line_d  = '0;
      pos_d   = '0;
      first_d = '0;
      eq_d    = 1'b0;
      empty_d = 1'b0;
      found_d = 1'b0;
      fkind_d = GO_NONE;
      fidx_d  = '0;
      fmark_d = '0;
    end

    if (clear_go_i) begin
      go_valid_d  = 1'b0;
      go_kind_d   = GO_NONE;
      go_index_d  = '0;
      go_winner_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q      <= '0;
      pos_q       <= '0;
      first_q     <= '0;
      eq_q        <= 1'b0;
      empty_q     <= 1'b0;
      found_q     <= 1'b0;
      fkind_q     <= GO_NONE;
      fidx_q      <= '0;
      fmark_q     <= '0;
      go_valid_q  <= 1'b0;
      go_kind_q   <= GO_NONE;
      go_index_q  <= '0;
      go_winner_q <= '0;
    end else begin
      line_q      <= line_d;
      pos_q       <= pos_d;
      first_q     <= first_d;
      eq_q        <= eq_d;
      empty_q     <= empty_d;
      found_q     <= found_d;
      fkind_q     <= fkind_d;
      fidx_q      <= fidx_d;
      fmark_q     <= fmark_d;
      go_valid_q  <= go_valid_d;
      go_kind_q   <= go_kind_d;
      go_index_q  <= go_index_d;
      go_winner_q <= go_winner_d;
    end
  end

  assign go_valid_o  = go_valid_q;
  assign go_kind_o   = go_kind_q;
  assign go_index_o  = go_index_q;
  assign go_winner_o = go_winner_q;

endmodule

// File: rtl/board_store.sv
// Live board + VGA shadow copy with a multi-cycle snapshot/clear engine and
// a continuously running win/draw scanner.
//   state | meaning
//   READY | writes accepted, save starts a snapshot
//   SNAP  | copying one live cell per cycle into the shadow
//   CLEAR | zeroing one live cell per cycle after a finished game
module board_store
  import board_pkg::*;
#(
  parameter int SIDE   = 4,
  parameter int CELL_W = 2,
  parameter int AW     = $clog2(SIDE * SIDE)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wen,
  input  logic [AW-1:0]           waddr,
  input  logic [CELL_W-1:0]       wdata,
  output logic                    wready,
  output logic [CELL_W-1:0]       wrdata,
  input  logic [AW-1:0]           raddr,
  output logic [CELL_W-1:0]       rdata,
  input  logic                    save,
  output logic                    snap_busy,
  output logic                    snap_done,
  output logic                    go_valid,
  output logic [2:0]              go_kind,
  output logic [$clog2(SIDE)-1:0] go_index,
  output logic [CELL_W-1:0]       go_winner
);

  localparam int DEPTH = SIDE * SIDE;
  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

  logic [CELL_W-1:0] mem_q    [DEPTH];
  logic [CELL_W-1:0] shadow_q [DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          snap_done_q, snap_done_d;
  logic          do_write, restart, clear_go, accept, cnt_last;
  logic          waddr_ok, raddr_ok;
  logic [AW-1:0]     scan_addr;
  logic [CELL_W-1:0] scan_cell;

  assign waddr_ok = ({1'b0, waddr} < DEPTH_V);
  assign raddr_ok = ({1'b0, raddr} < DEPTH_V);
  assign accept   = wen && (state_q == READY);
  assign cnt_last = (cnt_q == AW'(DEPTH - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    snap_done_d = 1'b0;
    do_write    = 1'b0;
    restart     = 1'b0;
    clear_go    = 1'b0;
    unique case (state_q)
      READY: begin
        if (accept) begin
          restart = 1'b1;
          if (go_valid) begin
            state_d  = CLEAR;
            cnt_d    = '0;
            clear_go = 1'b1;
            pend_d   = save;
          end else begin
            do_write = waddr_ok;
            if (save) begin
              state_d = SNAP;
              cnt_d   = '0;
            end
          end
        end else if (save) begin
          state_d = SNAP;
          cnt_d   = '0;
        end
      end
      SNAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_last) begin
          state_d     = READY;
          cnt_d       = '0;
          snap_done_d = 1'b1;
        end
      end
      CLEAR: begin
        // Hold the scanner idle so a pass cannot latch a half-cleared board.
        restart = 1'b1;
        pend_d  = pend_q || save;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_last) begin
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = (pend_q || save) ? SNAP : READY;
        end
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= READY;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      snap_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      snap_done_q <= snap_done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      if (state_q == CLEAR)   mem_q[cnt_q] <= '0;
      else if (do_write)      mem_q[waddr] <= wdata;
      if (state_q == SNAP)    shadow_q[cnt_q] <= mem_q[cnt_q];
    end
  end

  assign scan_cell = mem_q[scan_addr];

  win_scanner #(
    .SIDE   (SIDE),
    .CELL_W (CELL_W),
    .AW     (AW),
    .IW     ($clog2(SIDE))
  ) u_scanner (
    .clk         (clk),
    .rst_n       (rst_n),
    .restart_i   (restart),
    .clear_go_i  (clear_go),
    .cell_i      (scan_cell),
    .cell_addr_o (scan_addr),
    .go_valid_o  (go_valid),
    .go_kind_o   (go_kind),
    .go_index_o  (go_index),
    .go_winner_o (go_winner)
  );

  assign wready    = (state_q == READY);
  assign snap_busy = (state_q == SNAP);
  assign snap_done = snap_done_q;
  assign wrdata    = waddr_ok ? mem_q[waddr] : '0;
  assign rdata     = raddr_ok ? shadow_q[raddr] : '0;

endmodule

// File: tb/tb_board_store.sv
// Directed bench for board_store (SIDE=4, CELL_W=2): snapshot, win kinds,
// draw, auto-clear, save during CLEAR, save+write, reset mid-snapshot.
module tb_board_store;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wen = 1'b0;
  logic       save = 1'b0;
  logic [3:0] waddr = '0;
  logic [3:0] raddr = '0;
  logic [1:0] wdata = '0;
  logic       wready, snap_busy, snap_done, go_valid;
  logic [1:0] wrdata, rdata, go_winner, go_index;
  logic [2:0] go_kind;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  board_store #(.SIDE(4), .CELL_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata),
    .wready    (wready),
    .wrdata    (wrdata),
    .raddr     (raddr),
    .rdata     (rdata),
    .save      (save),
    .snap_busy (snap_busy),
    .snap_done (snap_done),
    .go_valid  (go_valid),
    .go_kind   (go_kind),
    .go_index  (go_index),
    .go_winner (go_winner)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [1:0] v);
    wen = 1'b1; waddr = a; wdata = v;
    @(negedge clk);
    wen = 1'b0;
  endtask

  // Each waiter returns the cycle offset (relative to the caller's start) of the event.
  task automatic wait_go(input int start, output int cyc);
    cyc = start;
    while (!go_valid && cyc < 80) begin @(negedge clk); cyc++; end
  endtask

  task automatic wait_ready(input int start, output int cyc);
    cyc = start;
    while (!wready && cyc < 80) begin @(negedge clk); cyc++; end
  endtask

  task automatic wait_done(input int start, output int cyc);
    cyc = start;
    while (!snap_done && cyc < 80) begin @(negedge clk); cyc++; end
  endtask

  function automatic logic [1:0] draw_v(input int a);
    int r, c;
    r = a / 4;
    c = a % 4;
    return (((r % 2) == 0) != (c >= 2)) ? 2'd1 : 2'd2;
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    raddr = 4'd5; waddr = 4'd5;
    #1;
    chk("rst_wready", wready, 1);
    chk("rst_busy", snap_busy, 0);
    chk("rst_done", snap_done, 0);
    chk("rst_go_valid", go_valid, 0);
    chk("rst_go_kind", go_kind, 0);
    chk("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // write then snapshot
    wr(4'd5, 2'd1);
    chk("wr_readback", wrdata, 1);
    chk("shadow_before_save", rdata, 0);
    save = 1'b1;
    @(negedge clk);
    save = 1'b0;
    chk("snap_busy_t1", snap_busy, 1);
    chk("snap_wready_t1", wready, 0);
    wait_done(1, n);
    chk("snap_done_latency", n, 17);
    chk("snap_busy_after", snap_busy, 0);
    chk("shadow_after_save", rdata, 1);
    @(negedge clk);
    chk("snap_done_pulse", snap_done, 0);

    // row 2 win
    for (int a = 8; a < 12; a++) wr(4'(a), 2'd2);
    wait_go(1, n);
    chk("row_go_latency", n, 41);
    chk("row_kind", go_kind, 1);
    chk("row_index", go_index, 2);
    chk("row_winner", go_winner, 2);

    // game over: next write clears instead of writing
    wr(4'd0, 2'd1);
    chk("clr_go_zero", go_valid, 0);
    chk("clr_wready_low", wready, 0);
    chk("clr_no_write", wrdata, 0);
    wait_ready(1, n);
    chk("clr_wready_return", n, 17);
    for (int i = 0; i < 16; i++) begin
      waddr = 4'(i); #1;
      chk("clr_cell_zero", wrdata, 0);
    end
    @(negedge clk);

    // column 0 precedes anti-diagonal
    wr(4'd3, 2'd1); wr(4'd6, 2'd1); wr(4'd9, 2'd1); wr(4'd12, 2'd1);
    wr(4'd0, 2'd1); wr(4'd4, 2'd1); wr(4'd8, 2'd1);
    wait_go(1, n);
    chk("col_go_latency", n, 41);
    chk("col_kind", go_kind, 2);
    chk("col_index", go_index, 0);
    chk("col_winner", go_winner, 1);

    // save during CLEAR: snapshot of the cleared board follows
    wr(4'd5, 2'd2);
    save = 1'b1;
    @(negedge clk);
    save = 1'b0;
    repeat (14) @(negedge clk);
    chk("pend_clear_last", snap_busy, 0);
    chk("pend_wready_low", wready, 0);
    @(negedge clk);
    chk("pend_snap_start", snap_busy, 1);
    wait_done(17, n);
    chk("pend_snap_done", n, 33);
    chk("pend_wready", wready, 1);
    for (int i = 0; i < 16; i++) begin
      raddr = 4'(i); #1;
      chk("pend_shadow_zero", rdata, 0);
    end
    @(negedge clk);

    // draw
    for (int a = 0; a < 16; a++) wr(4'(a), draw_v(a));
    wait_go(1, n);
    chk("draw_latency", n, 41);
    chk("draw_valid", go_valid, 1);
    chk("draw_kind", go_kind, 5);
    chk("draw_winner", go_winner, 0);
    chk("draw_index", go_index, 0);
    wr(4'd1, 2'd1);
    chk("draw_clr_go", go_valid, 0);
    chk("draw_clr_kind", go_kind, 0);
    wait_ready(1, n);
    chk("draw_clr_len", n, 17);
    for (int i = 0; i < 16; i++) begin
      waddr = 4'(i); #1;
      chk("draw_cell_zero", wrdata, 0);
    end
    @(negedge clk);
    repeat (45) @(negedge clk);
    chk("empty_no_go", go_valid, 0);

    // save and write in the same cycle
    wen = 1'b1; save = 1'b1; waddr = 4'd0; wdata = 2'd1;
    @(negedge clk);
    wen = 1'b0; save = 1'b0;
    chk("sw_busy", snap_busy, 1);
    chk("sw_write_landed", wrdata, 1);
    wait_done(1, n);
    chk("sw_done_latency", n, 17);
    raddr = 4'd0; #1;
    chk("sw_shadow0", rdata, 1);
    raddr = 4'd1; #1;
    chk("sw_shadow1", rdata, 0);
    @(negedge clk);

    // reset mid-snapshot
    save = 1'b1;
    @(negedge clk);
    save = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", snap_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", snap_busy, 0);
    chk("rst_mid_wready", wready, 1);
    raddr = 4'd0; waddr = 4'd0; #1;
    chk("rst_mid_shadow", rdata, 0);
    chk("rst_mid_mem", wrdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
